// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer
// Walks an LDM/STM register list lowest register first, issuing one memory
// request per listed register and driving the register-file write port for
// loads and the read select for stores.
// Optional feature macro: LDMSTM_BASE_WB_EN (adds the base-writeback WB state).
module ldm_stm_sequencer #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [15:0]           REGLIST,
  input  logic [3:0]            RN,
  input  logic [ADDR_WIDTH-1:0] BASE,
  input  logic                  L,
  input  logic                  U,
  input  logic                  P,
  input  logic                  W,
  input  logic                  MEMRDY,
  input  logic [31:0]           MEMDATA,
  output logic                  MEMREQ,
  output logic                  MEMRW,
  output logic [ADDR_WIDTH-1:0] ADDR,
  output logic [3:0]            RDSEL,
  output logic [3:0]            WRSEL,
  output logic                  WREN_N,
  output logic [ADDR_WIDTH-1:0] WDATA,
  output logic                  BUSY,
  output logic                  DONE
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    FIN
`ifdef LDMSTM_BASE_WB_EN
    , WB
`endif
  } state_t;

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  state_t                  state, next_state;
  logic [15:0]             mask;
  logic                    l_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [3:0]              rdsel_q, wrsel_q;
  logic [ADDR_WIDTH-1:0]   wdata_q;
  logic [ADDR_WIDTH-1:0]   span, start_addr;
  logic [3:0]              cur;
  logic                    last, in_xfer, wr_load, wr_wb, wb_pending;
  logic [3:0]              wb_sel;
  logic [ADDR_WIDTH-1:0]   wb_data;

  assign span    = ADDR_WIDTH'({popcount(REGLIST), 2'b00});
  assign cur     = lowest_set(mask);
  assign last    = (mask & (mask - 16'd1)) == 16'd0;
  assign in_xfer = (state == XFER) && !RST;
  assign wr_load = in_xfer && MEMRDY && l_q;

`ifdef LDMSTM_BASE_WB_EN
  logic [3:0]            rn_q;
  logic                  wb_q;
  logic [ADDR_WIDTH-1:0] new_base_q;
  logic [ADDR_WIDTH-1:0] new_base;

  assign new_base   = U ? (BASE + span) : (BASE - span);
  assign wr_wb      = (state == WB) && !RST;
  assign wb_pending = wb_q;
  assign wb_sel     = rn_q;
  assign wb_data    = new_base_q;

  // Latch the writeback target and decide up front whether a loaded Rn overrides it
  always_ff @(posedge CLK) begin
    if (RST) begin
      rn_q       <= '0;
      wb_q       <= 1'b0;
      new_base_q <= '0;
    end else if (state == IDLE && START) begin
      rn_q       <= RN;
      wb_q       <= W && !(L && REGLIST[RN]);
      new_base_q <= new_base;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{RN, W};
  assign wr_wb      = 1'b0;
  assign wb_pending = 1'b0;
  assign wb_sel     = '0;
  assign wb_data    = '0;
`endif

  // First transfer address for the four addressing modes
  always_comb begin
    start_addr = BASE;
    case ({U, P})
      2'b10:   start_addr = BASE;
      2'b11:   start_addr = BASE + ADDR_WIDTH'(4);
      2'b00:   start_addr = BASE - span + ADDR_WIDTH'(4);
      default: start_addr = BASE - span;
    endcase
  end

  // Next-state selection; an empty list skips straight to FIN
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (START) next_state = (REGLIST == 16'd0) ? FIN : XFER;
      XFER: begin
        if (MEMRDY && last) begin
`ifdef LDMSTM_BASE_WB_EN
          next_state = wb_pending ? WB : FIN;
`else
          next_state = FIN;
`endif
        end
      end
`ifdef LDMSTM_BASE_WB_EN
      WB:   next_state = FIN;
`endif
      FIN:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, pending mask, address and the held output values
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      mask    <= '0;
      l_q     <= 1'b0;
      addr_q  <= '0;
      rdsel_q <= '0;
      wrsel_q <= '0;
      wdata_q <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && START) begin
        mask <= REGLIST;
        l_q  <= L;
        if (REGLIST != 16'd0) addr_q <= start_addr;
      end
      if (state == XFER) begin
        rdsel_q <= cur;
        if (MEMRDY) begin
          mask <= mask & (mask - 16'd1);
          if (!last) addr_q <= addr_q + ADDR_WIDTH'(4);
        end
      end
      if (wr_load) begin
        wrsel_q <= cur;
        wdata_q <= ADDR_WIDTH'(MEMDATA);
      end else if (wr_wb) begin
        wrsel_q <= wb_sel;
        wdata_q <= wb_data;
      end
    end
  end

  assign MEMREQ = in_xfer;
  assign MEMRW  = in_xfer && !l_q;
  assign ADDR   = addr_q;
  assign RDSEL  = (state == XFER) ? cur : rdsel_q;
  assign WREN_N = !(wr_load || wr_wb);
  assign WRSEL  = wr_load ? cur : (wr_wb ? wb_sel : wrsel_q);
  assign WDATA  = wr_load ? ADDR_WIDTH'(MEMDATA) : (wr_wb ? wb_data : wdata_q);
  assign BUSY   = (state != IDLE);
  assign DONE   = (state == FIN);

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: expected transfers are queued when
// an operation is started and popped as the DUT issues each completed request.
module tb_ldm_stm_sequencer;

`ifdef LDMSTM_BASE_WB_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, l_in, u_in, p_in, w_in, memrdy;
  logic [15:0] reglist;
  logic [3:0]  rn;
  logic [31:0] base_in, memdata;
  logic        memreq, memrw, wren_n, busy, done;
  logic [31:0] addr, wdata;
  logic [3:0]  rdsel, wrsel;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [3:0]  rg;
  } xfer_t;

  xfer_t exp_q[$];

  ldm_stm_sequencer #(.ADDR_WIDTH(32)) dut (
    .CLK(clk), .RST(rst), .START(start), .REGLIST(reglist), .RN(rn),
    .BASE(base_in), .L(l_in), .U(u_in), .P(p_in), .W(w_in),
    .MEMRDY(memrdy), .MEMDATA(memdata), .MEMREQ(memreq), .MEMRW(memrw),
    .ADDR(addr), .RDSEL(rdsel), .WRSEL(wrsel), .WREN_N(wren_n),
    .WDATA(wdata), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  // Start one LDM/STM, queue its expected transfers and check it cycle by cycle
  task automatic run_op(input string name, input logic [15:0] list, input logic [3:0] rnum,
                        input logic [31:0] base, input logic l, input logic u, input logic p,
                        input logic w, input int stall_idx, input int stall_len, input bit poke_busy);
    int n, done_exp, done_cyc, xfers, stalled, wb_seen;
    logic [31:0] a, nb;
    bit wb_exp, done_seen;
    n  = $countones(list);
    a  = u ? (p ? base + 32'd4 : base) : (p ? base - 32'(4 * n) : base - 32'(4 * n) + 32'd4);
    nb = u ? base + 32'(4 * n) : base - 32'(4 * n);
    wb_exp = WB_EN && w && (n != 0) && !(l && list[rnum]);
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        exp_q.push_back('{addr: a, rw: !l, rg: 4'(i)});
        a = a + 32'd4;
      end
    end
    done_exp = n + (wb_exp ? 1 : 0) + 1 + ((stall_idx < n) ? stall_len : 0);
    @(posedge clk); #1;
    start = 1'b1; reglist = list; rn = rnum; base_in = base;
    l_in = l; u_in = u; p_in = p; w_in = w;
    @(posedge clk); #1;
    start = 1'b0; reglist = 16'hFFFF; rn = ~rnum; base_in = 32'hDEAD_BEEF;
    l_in = ~l; u_in = ~u; p_in = ~p; w_in = ~w;
    done_seen = 1'b0; done_cyc = 0; xfers = 0; stalled = 0; wb_seen = 0;
    for (int c = 1; c <= 64 && !done_seen; c++) begin
      start = poke_busy && (c == 2);
      if (xfers == stall_idx && stalled < stall_len) begin
        memrdy = 1'b0; stalled++;
      end else begin
        memrdy = 1'b1;
      end
      memdata = $urandom;
      @(negedge clk);
      if (memreq) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL %s unexpected_req: MEMREQ=1 at ADDR=%h, required no request", name, addr);
        end else begin
          if (addr !== exp_q[0].addr) begin
            errors++;
            $display("[TB] FAIL %s addr: got %h required %h", name, addr, exp_q[0].addr);
          end
          checks++;
          if (rdsel !== exp_q[0].rg) begin
            errors++;
            $display("[TB] FAIL %s rdsel: got %0d required %0d", name, rdsel, exp_q[0].rg);
          end
          checks++;
          if (memrw !== exp_q[0].rw) begin
            errors++;
            $display("[TB] FAIL %s memrw: got %b required %b", name, memrw, exp_q[0].rw);
          end
          checks++;
          if (memrdy && !exp_q[0].rw) begin
            if (wren_n !== 1'b0 || wrsel !== exp_q[0].rg || wdata !== memdata) begin
              errors++;
              $display("[TB] FAIL %s load_write: got wren_n=%b wrsel=%0d wdata=%h required 0/%0d/%h",
                       name, wren_n, wrsel, wdata, exp_q[0].rg, memdata);
            end
          end else if (wren_n !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s no_write: got wren_n=%b required 1", name, wren_n);
          end
          if (memrdy) begin
            void'(exp_q.pop_front());
            xfers++;
          end
        end
      end else if (!wren_n) begin
        checks++;
        if (!wb_exp || wb_seen != 0) begin
          errors++;
          $display("[TB] FAIL %s unexpected_write: wren_n=0 wrsel=%0d, required no write", name, wrsel);
        end else if (wrsel !== rnum || wdata !== nb) begin
          errors++;
          $display("[TB] FAIL %s writeback: got wrsel=%0d wdata=%h required %0d/%h",
                   name, wrsel, wdata, rnum, nb);
        end
        wb_seen++;
      end
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = c;
      end else begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (done_cyc != done_exp) begin
      errors++;
      $display("[TB] FAIL %s done_cycle: got %0d required %0d", name, done_cyc, done_exp);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s transfers_left: got %0d required 0", name, exp_q.size());
    end
    checks++;
    if (wb_seen != (wb_exp ? 1 : 0)) begin
      errors++;
      $display("[TB] FAIL %s wb_count: got %0d required %0d", name, wb_seen, wb_exp ? 1 : 0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s idle_after: got busy=%b done=%b required 0/0", name, busy, done);
    end
  endtask

  // Verify every output sits at its reset value
  task automatic check_reset_values(input string name);
    checks++;
    if (memreq !== 1'b0 || memrw !== 1'b0 || addr !== 32'd0 || rdsel !== 4'd0 ||
        wrsel !== 4'd0 || wren_n !== 1'b1 || wdata !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s reset_values: got req=%b rw=%b addr=%h rd=%0d wr=%0d wren_n=%b wdata=%h busy=%b done=%b required 0 0 0 0 0 1 0 0 0",
               name, memreq, memrw, addr, rdsel, wrsel, wren_n, wdata, busy, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("after_reset");
  endtask

  task automatic test_ldmia();
    run_op("ldmia", 16'h000B, 4'd5, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 99, 0, 1'b0);
  endtask

  task automatic test_stmdb_wb();
    run_op("stmdb_wb", 16'h4010, 4'd13, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 99, 0, 1'b0);
  endtask

  task automatic test_ldmib_rn_in_list();
    run_op("ldmib_rn", 16'h0085, 4'd2, 32'h300, 1'b1, 1'b1, 1'b1, 1'b1, 99, 0, 1'b0);
  endtask

  task automatic test_stall();
    run_op("stall", 16'h000F, 4'd9, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 1, 3, 1'b0);
  endtask

  task automatic test_empty();
    run_op("empty", 16'h0000, 4'd1, 32'h800, 1'b1, 1'b1, 1'b0, 1'b1, 99, 0, 1'b0);
  endtask

  task automatic test_wrap_busy_start();
    run_op("wrap", 16'h0181, 4'd4, 32'h4, 1'b0, 1'b0, 1'b1, 1'b1, 99, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    exp_q.delete();
    @(posedge clk); #1;
    start = 1'b1; reglist = 16'h0F00; rn = 4'd1; base_in = 32'h500;
    l_in = 1'b1; u_in = 1'b1; p_in = 1'b0; w_in = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; memrdy = 1'b1; memdata = 32'hCAFE_0008;
    @(negedge clk);
    checks++;
    if (memreq !== 1'b1 || addr !== 32'h500 || wren_n !== 1'b0 || wrsel !== 4'd8 || wdata !== 32'hCAFE_0008) begin
      errors++;
      $display("[TB] FAIL reset_mid first_xfer: got req=%b addr=%h wren_n=%b wrsel=%0d wdata=%h required 1/500/0/8/cafe0008",
               memreq, addr, wren_n, wrsel, wdata);
    end
    @(posedge clk); #1;
    rst = 1'b1; memrdy = 1'b1;
    @(negedge clk);
    checks++;
    if (memreq !== 1'b0 || wren_n !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid rst_cycle: got req=%b wren_n=%b required 0/1", memreq, wren_n);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset_mid");
    run_op("after_rst", 16'h0003, 4'd7, 32'h600, 1'b1, 1'b1, 1'b0, 1'b0, 99, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      run_op("b2b", 16'($urandom), 4'($urandom), $urandom & 32'hFFFF_FFFC,
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; reglist = '0; rn = '0; base_in = '0;
    l_in = 1'b0; u_in = 1'b0; p_in = 1'b0; w_in = 1'b0; memrdy = 1'b0; memdata = '0;
    test_reset();
    test_ldmia();
    test_stmdb_wb();
    test_ldmib_rn_in_list();
    test_stall();
    test_empty();
    test_wrap_busy_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
